instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 4, giving the number of instruction queue entries (power of two, minimum 2).
REQ-002 The block SHALL provide parameter RESET_PC, default 16'h0000, giving the first fetch address after reset.
REQ-003 clk  input  1  single rising-edge clock; the instruction ROM is clocked on the same edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 rom_addr  output  16  instruction ROM word address; driven combinationally from the fetch PC register.
REQ-006 rom_data  input  24  ROM read data, valid one cycle after the edge that sampled rom_addr.
REQ-007 halt_req  input  1  stop issuing new fetches while high.
REQ-008 redirect  input  1  branch/jump taken; flush and restart fetch at redirect_pc.
REQ-009 redirect_pc  input  16  new fetch address, sampled when redirect=1.
REQ-010 inst_ready  input  1  downstream asip accepts the head instruction this cycle.
REQ-011 inst_valid  output  1  queue head holds a valid instruction.
REQ-012 inst  output  24  queue head instruction word.
REQ-013 inst_pc  output  16  address of the queue head instruction.
REQ-014 halted  output  1  high in state HALT with the queue empty and nothing in flight.

Function
REQ-015 FSM states SHALL be IDLE, RUN and HALT.
REQ-016 Transitions: IDLE->RUN on the first edge with reset=1; RUN->HALT when halt_req=1; HALT->RUN when halt_req=0 or redirect=1.
REQ-017 A fetch SHALL issue in a cycle iff state=RUN, halt_req=0, redirect=0 and count+inflight < DEPTH, with count = valid queue entries and inflight in {0,1}.
REQ-018 On issue: fetch_pc <= fetch_pc+1 (16-bit wrap, 16'hFFFF -> 16'h0000); inflight <= 1; inflight_pc <= fetch_pc.
REQ-019 When inflight=1 and no redirect: {rom_data, inflight_pc} SHALL be written at the queue tail on the edge ending that cycle; inflight clears unless a new issue occurs the same cycle.
REQ-020 Latency: address issued at edge E -> queue write at E+1 -> inst_valid high in the cycle after E+1 (two edges).
REQ-021 Pop SHALL occur iff inst_valid=1 and inst_ready=1 and redirect=0; simultaneous push and pop leave count unchanged.
REQ-022 inst_ready while inst_valid=0 SHALL be ignored; inst/inst_pc SHALL stay stable while inst_valid=1 and inst_ready=0.
REQ-023 Queue read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-024 redirect=1 SHALL have priority over pop, push, issue and halt_req: queue emptied, inflight cleared (returning rom_data discarded), fetch_pc <= redirect_pc, no issue that cycle.
REQ-025 After redirect at edge R, the first issue SHALL be at R+1 with rom_addr=redirect_pc, and inst_valid SHALL be low from R through R+2.
REQ-026 In HALT, an in-flight response SHALL still be queued, and queued instructions SHALL still pop.
REQ-027 With sustained inst_ready=1, the block SHALL sustain one instruction per cycle.

Reset
REQ-028 While reset=0 at an edge: state IDLE, fetch_pc=RESET_PC, count=0, pointers=0, inflight=0.
REQ-029 Outputs under reset: inst_valid=0, inst=24'h0, inst_pc=16'h0, halted=0, rom_addr=RESET_PC.
REQ-030 Reset asserted mid-operation SHALL discard all queued and in-flight instructions on that edge, regardless of redirect or inst_ready.

Verification
REQ-031 Startup: release reset, ROM[0..3]=A,B,C,D, inst_ready=1 -> inst_valid high two edges after the first issue; inst=A,B,C,D with inst_pc 0,1,2,3 on consecutive cycles.
REQ-032 Backpressure: inst_ready=0 for 10 cycles -> at most 4 issues, count=4, rom_addr frozen, inst=A held; then inst_ready=1 -> A..D followed by E with no gap or duplicate.
REQ-033 Redirect: redirect=1, redirect_pc=16'h0040 while inflight=1 and count=2 -> inst_valid low for 3 cycles; the next inst_pc is 16'h0040 and no stale word appears.
REQ-034 Wrap: redirect_pc=16'hFFFE -> inst_pc sequence FFFE, FFFF, 0000, 0001.
REQ-035 Halt: halt_req=1 mid-stream -> no new issue; the queue drains; halted=1 once count=0; halt_req=0 -> fetch resumes at the next sequential pc.
REQ-036 Mid-run reset: reset=0 for one edge with count=3 -> the next cycle has inst_valid=0, count=0 and rom_addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential ROM fetches into a small instruction
// queue, handles redirects (flush and restart) and halt requests.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] rom_addr,
    input  logic [23:0] rom_data,
    input  logic        halt_req,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [23:0] inst,
    output logic [15:0] inst_pc,
    output logic        halted
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW:0] DepthOcc = (CntW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e            state_q, state_d;
    logic [15:0]       fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [15:0]       inflight_pc_q, inflight_pc_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [23:0]       mem_inst_q [DEPTH];
    logic [23:0]       mem_inst_d [DEPTH];
    logic [15:0]       mem_pc_q [DEPTH];
    logic [15:0]       mem_pc_d [DEPTH];

    logic        issue;
    logic        push;
    logic        pop;
    logic [CntW:0] occupancy;

    // Output decode; the head is hidden during a redirect because it is being flushed.
    always_comb begin
        rom_addr   = fetch_pc_q;
        inst_valid = (count_q != '0) && !redirect;
        inst       = inst_valid ? mem_inst_q[rd_ptr_q] : 24'h0;
        inst_pc    = inst_valid ? mem_pc_q[rd_ptr_q] : 16'h0;
        halted     = (state_q == StHalt) && (count_q == '0) && !inflight_q;
    end

    // FSM next state; redirect wins over halt_req.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  state_d = StRun;
            StRun:   if (halt_req && !redirect) state_d = StHalt;
            StHalt:  if (!halt_req || redirect) state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    // Fetch issue, queue push/pop and pointer/count bookkeeping.
    always_comb begin
        // Issue only if the returning word is guaranteed a free slot.
        occupancy = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
        issue     = (state_q == StRun) && !halt_req && !redirect && (occupancy < DepthOcc);
        push      = inflight_q && !redirect;
        pop       = inst_valid && inst_ready;

        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        mem_inst_d    = mem_inst_q;
        mem_pc_d      = mem_pc_q;

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            inflight_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                mem_inst_d[wr_ptr_q] = rom_data;
                mem_pc_d[wr_ptr_q]   = inflight_pc_q;
                wr_ptr_d             = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
            // The in-flight slot clears on return unless refilled by a new issue.
            inflight_d = issue;
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + 16'd1;
                inflight_pc_d = fetch_pc_q;
            end
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 16'h0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        mem_inst_q <= mem_inst_d;
        mem_pc_q   <= mem_pc_d;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: scoreboard of expected {pc, word}
// pairs, hand-written corner sequences and a table of redirect/drain vectors.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rom_addr;
    logic [23:0] rom_data;
    logic        halt_req;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        inst_ready;
    logic        inst_valid;
    logic [23:0] inst;
    logic [15:0] inst_pc;
    logic        halted;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .halt_req    (halt_req),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_ready  (inst_ready),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .halted      (halted)
    );

    // ROM contents: a distinct word per address.
    function automatic logic [23:0] rom_fn(input logic [15:0] a);
        return {~a[7:0], a ^ 16'h3C3C};
    endfunction

    // Synchronous ROM, one cycle read latency.
    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    typedef struct packed {
        logic [15:0] pc;
        logic [23:0] word;
    } exp_t;

    typedef struct {
        logic [15:0] start;
        int          n;
        logic [7:0]  pat;
        logic [15:0] exp_last;
        int          exp_cycles;
    } vec_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          accepts = 0;
    logic [15:0] last_pc = 16'h0;
    logic        seen_valid = 1'b0;
    int          waited;
    int          a0;
    int          cyc;
    vec_t        vecs[5];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One cycle: sample outputs mid-cycle, score any accepted instruction, advance.
    task automatic tick();
        exp_t e;
        #1;
        seen_valid = inst_valid;
        if (inst_valid && inst_ready) begin
            accepts++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got pc %0h want no instruction", inst_pc);
            end else begin
                e = sb.pop_front();
                check("sb_pc", 40'(inst_pc), 40'(e.pc));
                check("sb_inst", 40'(inst), 40'(e.word));
                last_pc = inst_pc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] start, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc   = start + 16'(i);
            e.word = rom_fn(e.pc);
            sb.push_back(e);
        end
    endtask

    task automatic redirect_to(input logic [15:0] pc);
        inst_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = pc;
        tick();
        redirect = 1'b0;
        sb.delete();
    endtask

    task automatic run_until_drained(input logic [7:0] pat, input int budget, output int cycles);
        cycles = 0;
        while (sb.size() != 0 && cycles < budget) begin
            inst_ready = pat[cycles[2:0]];
            tick();
            cycles++;
        end
        inst_ready = 1'b0;
        check("drained", 40'(sb.size()), 40'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h0040, 6, 8'hFF, 16'h0045, 8};
        vecs[1] = '{16'hFFFE, 4, 8'hFF, 16'h0001, 6};
        vecs[2] = '{16'h1230, 8, 8'hA6, 16'h1237, 0};
        vecs[3] = '{16'h00F0, 5, 8'h01, 16'h00F4, 0};
        vecs[4] = '{16'h7FFF, 3, 8'hCC, 16'h8001, 0};

        reset       = 1'b0;
        halt_req    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0;
        inst_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 40'(inst_valid), 40'd0);
        check("rst_inst", 40'(inst), 40'd0);
        check("rst_inst_pc", 40'(inst_pc), 40'd0);
        check("rst_halted", 40'(halted), 40'd0);
        check("rst_rom_addr", 40'(rom_addr), 40'h0000);

        // Startup: first word two edges after the first issue, then one per cycle.
        reset      = 1'b1;
        inst_ready = 1'b1;
        push_exp(16'h0000, 4);
        waited = 0;
        while (!inst_valid && waited < 10) begin
            tick();
            waited++;
        end
        check("startup_latency", 40'(waited), 40'd3);
        a0 = accepts;
        repeat (4) tick();
        check("startup_stream", 40'(accepts - a0), 40'd4);
        check("startup_sb_empty", 40'(sb.size()), 40'd0);
        inst_ready = 1'b0;

        // Backpressure: queue fills to DEPTH and fetch stops.
        redirect_to(16'h0000);
        repeat (10) tick();
        check("bp_rom_addr", 40'(rom_addr), 40'h0004);
        check("bp_valid", 40'(inst_valid), 40'd1);
        check("bp_head_pc", 40'(inst_pc), 40'h0000);
        check("bp_head_inst", 40'(inst), 40'(rom_fn(16'h0000)));
        tick();
        check("bp_rom_addr_frozen", 40'(rom_addr), 40'h0004);
        check("bp_head_held", 40'(inst_pc), 40'h0000);
        push_exp(16'h0000, 5);
        inst_ready = 1'b1;
        a0 = accepts;
        repeat (5) tick();
        inst_ready = 1'b0;
        check("bp_release_stream", 40'(accepts - a0), 40'd5);
        check("bp_sb_empty", 40'(sb.size()), 40'd0);

        // Redirect with two queued words and one fetch in flight.
        redirect_to(16'h0100);
        repeat (3) tick();
        check("rd_pre_valid", 40'(inst_valid), 40'd1);
        check("rd_pre_pc", 40'(inst_pc), 40'h0100);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        inst_ready  = 1'b1;
        tick();
        check("rd_invalid_c0", 40'(seen_valid), 40'd0);
        redirect = 1'b0;
        push_exp(16'h0040, 4);
        tick();
        check("rd_invalid_c1", 40'(seen_valid), 40'd0);
        tick();
        check("rd_invalid_c2", 40'(seen_valid), 40'd0);
        run_until_drained(8'hFF, 20, cyc);
        check("rd_first_run", 40'(cyc), 40'd4);

        // Table: redirect, then drain a known run under a ready pattern.
        for (int i = 0; i < 5; i++) begin
            redirect_to(vecs[i].start);
            push_exp(vecs[i].start, vecs[i].n);
            run_until_drained(vecs[i].pat, 200, cyc);
            check($sformatf("vec%0d_last_pc", i), 40'(last_pc), 40'(vecs[i].exp_last));
            if (vecs[i].exp_cycles != 0)
                check($sformatf("vec%0d_cycles", i), 40'(cyc), 40'(vecs[i].exp_cycles));
        end

        // Halt: stop fetching, drain, report halted, resume sequentially.
        redirect_to(16'h0200);
        repeat (8) tick();
        halt_req = 1'b1;
        push_exp(16'h0200, 4);
        tick();
        check("halt_busy", 40'(halted), 40'd0);
        run_until_drained(8'hFF, 20, cyc);
        check("halt_halted", 40'(halted), 40'd1);
        check("halt_no_valid", 40'(inst_valid), 40'd0);
        repeat (3) tick();
        check("halt_rom_addr", 40'(rom_addr), 40'h0204);
        check("halt_still", 40'(halted), 40'd1);
        halt_req = 1'b0;
        push_exp(16'h0204, 4);
        run_until_drained(8'hFF, 20, cyc);
        check("resume_not_halted", 40'(halted), 40'd0);

        // Mid-run reset with three queued words and a fetch in flight.
        redirect_to(16'h0300);
        repeat (4) tick();
        check("mr_pre_valid", 40'(inst_valid), 40'd1);
        reset       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0777;
        inst_ready  = 1'b1;
        tick();
        reset      = 1'b1;
        redirect   = 1'b0;
        inst_ready = 1'b0;
        #1;
        check("mr_valid", 40'(inst_valid), 40'd0);
        check("mr_rom_addr", 40'(rom_addr), 40'h0000);
        check("mr_inst", 40'(inst), 40'd0);
        check("mr_inst_pc", 40'(inst_pc), 40'd0);
        check("mr_halted", 40'(halted), 40'd0);
        push_exp(16'h0000, 4);
        run_until_drained(8'hFF, 20, cyc);
        check("mr_restart_cycles", 40'(cyc), 40'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
